// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle MIPS-style control FSM with fetch counter
// Moore outputs decoded from state; FETCH enables and DECODE illegal also depend on inputs.
module multicycle_ctrl #(
   parameter int STATE_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [5:0]         op,
   input  logic [5:0]         funct,
   input  logic               mem_ready,
   output logic               pc_write,
   output logic               pc_write_cond,
   output logic               iord,
   output logic               mem_read,
   output logic               mem_write,
   output logic               ir_write,
   output logic               reg_write,
   output logic               alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic [2:0]         alu_op,
   output logic [1:0]         reg_dst,
   output logic [1:0]         mem_to_reg,
   output logic [1:0]         pc_source,
   output logic               illegal,
   output logic [STATE_W-1:0] state,
   output logic [31:0]        instr_count
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,  S_JUMP   = 4'd9,  S_ADDIEX = 4'd10, S_ADDIWB = 4'd11,
      S_JAL    = 4'd12, S_JR     = 4'd13
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] FN_JR    = 6'b001000;

   state_t cur, nxt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cur <= S_FETCH;
      else     cur <= nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                               instr_count <= 32'd0;
      else if (cur == S_FETCH && mem_ready)  instr_count <= instr_count + 32'd1;
   end

   always_comb begin
      nxt           = S_FETCH;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 3'b000;
      reg_dst       = 2'b00;
      mem_to_reg    = 2'b00;
      pc_source     = 2'b00;
      illegal       = 1'b0;
      case (cur)
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
            nxt       = mem_ready ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            alu_src_b = 2'b11;
            case (op)
               OP_RTYPE:     nxt = (funct == FN_JR) ? S_JR : S_EXEC;
               OP_LW, OP_SW: nxt = S_MEMADR;
               OP_BEQ:       nxt = S_BRANCH;
               OP_J:         nxt = S_JUMP;
               OP_JAL:       nxt = S_JAL;
               OP_ADDI:      nxt = S_ADDIEX;
               default:      illegal = 1'b1;
            endcase
         end
         S_MEMADR, S_ADDIEX: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            if (cur == S_ADDIEX) nxt = S_ADDIWB;
            else                 nxt = (op == OP_SW) ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            mem_read = 1'b1;
            iord     = 1'b1;
            nxt      = mem_ready ? S_MEMWB : S_MEMRD;
         end
         S_MEMWR: begin
            mem_write = 1'b1;
            iord      = 1'b1;
            nxt       = mem_ready ? S_FETCH : S_MEMWR;
         end
         S_MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 2'b01;
         end
         S_EXEC: begin
            alu_src_a = 1'b1;
            alu_op    = 3'b010;
            nxt       = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write = 1'b1;
            reg_dst   = 2'b01;
         end
         S_ADDIWB: reg_write = 1'b1;
         S_BRANCH: begin
            alu_src_a     = 1'b1;
            alu_op        = 3'b001;
            pc_write_cond = 1'b1;
            pc_source     = 2'b01;
         end
         S_JUMP: begin
            pc_write  = 1'b1;
            pc_source = 2'b10;
         end
         S_JR: begin
            pc_write  = 1'b1;
            pc_source = 2'b11;
         end
         S_JAL: begin
            reg_write  = 1'b1;
            reg_dst    = 2'b10;
            mem_to_reg = 2'b10;
            pc_write   = 1'b1;
            pc_source  = 2'b10;
         end
         default: nxt = S_FETCH;
      endcase
      // Reset must silence every enable at once, not only after the next edge.
      if (rst) begin
         pc_write  = 1'b0;
         ir_write  = 1'b0;
         mem_read  = 1'b0;
         alu_src_b = 2'b00;
         illegal   = 1'b0;
      end
   end

   assign state = STATE_W'(cur);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard bench for multicycle_ctrl
// Expected per-cycle state and full control vector are queued as stimulus is driven.
module tb_multicycle_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  op, funct;
   logic        mem_ready;
   logic        pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, reg_write;
   logic        alu_src_a, illegal;
   logic [1:0]  alu_src_b, reg_dst, mem_to_reg, pc_source;
   logic [2:0]  alu_op;
   logic [3:0]  state;
   logic [31:0] instr_count;

   int errors = 0;
   int checks = 0;
   logic [31:0] exp_count = 32'd0;

   typedef struct {
      logic [3:0]  st;
      logic [19:0] v;
      string       name;
   } exp_t;
   exp_t q[$];

   // {pw,pwc,iord,mrd,mwr,irw,rw,ill} asa asb aop rd m2r ps
   localparam logic [19:0] E_ZERO    = 20'h0;
   localparam logic [19:0] E_FETCH_W = {8'h10, 1'b0, 2'b01, 3'b000, 2'b00, 2'b00, 2'b00};
   localparam logic [19:0] E_FETCH_R = {8'h94, 1'b0, 2'b01, 3'b000, 2'b00, 2'b00, 2'b00};
   localparam logic [19:0] E_DECODE  = {8'h00, 1'b0, 2'b11, 3'b000, 2'b00, 2'b00, 2'b00};
   localparam logic [19:0] E_ILL     = {8'h01, 1'b0, 2'b11, 3'b000, 2'b00, 2'b00, 2'b00};
   localparam logic [19:0] E_MEMADR  = {8'h00, 1'b1, 2'b10, 3'b000, 2'b00, 2'b00, 2'b00};
   localparam logic [19:0] E_MEMRD   = {8'h30, 1'b0, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00};
   localparam logic [19:0] E_MEMWB   = {8'h02, 1'b0, 2'b00, 3'b000, 2'b00, 2'b01, 2'b00};
   localparam logic [19:0] E_MEMWR   = {8'h28, 1'b0, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00};
   localparam logic [19:0] E_EXEC    = {8'h00, 1'b1, 2'b00, 3'b010, 2'b00, 2'b00, 2'b00};
   localparam logic [19:0] E_ALUWB   = {8'h02, 1'b0, 2'b00, 3'b000, 2'b01, 2'b00, 2'b00};
   localparam logic [19:0] E_ADDIWB  = {8'h02, 1'b0, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00};
   localparam logic [19:0] E_BRANCH  = {8'h40, 1'b1, 2'b00, 3'b001, 2'b00, 2'b00, 2'b01};
   localparam logic [19:0] E_JUMP    = {8'h80, 1'b0, 2'b00, 3'b000, 2'b00, 2'b00, 2'b10};
   localparam logic [19:0] E_JR      = {8'h80, 1'b0, 2'b00, 3'b000, 2'b00, 2'b00, 2'b11};
   localparam logic [19:0] E_JAL     = {8'h82, 1'b0, 2'b00, 3'b000, 2'b10, 2'b10, 2'b10};

   wire [19:0] obs = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, reg_write,
                      illegal, alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg, pc_source};

   multicycle_ctrl #(.STATE_W(4)) dut (
      .clk(clk), .rst(rst), .op(op), .funct(funct), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
      .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_op(alu_op), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
      .pc_source(pc_source), .illegal(illegal), .state(state),
      .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   // One clock cycle: called just after a rising edge, returns just after the next.
   task automatic cyc(input logic mr, input logic [3:0] st, input logic [19:0] v, input string name);
      exp_t e;
      mem_ready = mr;
      q.push_back('{st: st, v: v, name: name});
      @(negedge clk);
      e = q.pop_front();
      checks++;
      if (state !== e.st) begin
         errors++;
         $display("FAIL %s state: got %0d want %0d", e.name, state, e.st);
      end
      checks++;
      if (obs !== e.v) begin
         errors++;
         $display("FAIL %s ctrl: got %05h want %05h", e.name, obs, e.v);
      end
      checks++;
      if (instr_count !== exp_count) begin
         errors++;
         $display("FAIL %s instr_count: got %0d want %0d", e.name, instr_count, exp_count);
      end
      if (e.st == 4'd0 && mr) exp_count++;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; mem_ready = 1'b1; op = 6'b100011; funct = 6'b0;
      #2;
      checks++;
      if (state !== 4'd0) begin errors++; $display("FAIL reset state: got %0d want 0", state); end
      checks++;
      if (obs !== E_ZERO) begin errors++; $display("FAIL reset ctrl: got %05h want %05h", obs, E_ZERO); end
      checks++;
      if (instr_count !== 32'd0) begin errors++; $display("FAIL reset count: got %0d want 0", instr_count); end
      @(negedge clk);
      mem_ready = 1'b0;
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_lw();
      op = 6'b100011;
      cyc(1, 0, E_FETCH_R, "lw_fetch");
      cyc(1, 1, E_DECODE,  "lw_decode");
      cyc(1, 2, E_MEMADR,  "lw_memadr");
      cyc(1, 3, E_MEMRD,   "lw_memrd");
      cyc(1, 4, E_MEMWB,   "lw_memwb");
   endtask

   task automatic test_lw_wait();
      op = 6'b100011;
      cyc(1, 0, E_FETCH_R, "lww_fetch");
      cyc(0, 1, E_DECODE,  "lww_decode");
      cyc(0, 2, E_MEMADR,  "lww_memadr");
      cyc(0, 3, E_MEMRD,   "lww_memrd0");
      cyc(0, 3, E_MEMRD,   "lww_memrd1");
      cyc(1, 3, E_MEMRD,   "lww_memrd2");
      cyc(0, 4, E_MEMWB,   "lww_memwb");
   endtask

   task automatic test_rtype();
      op = 6'b000000; funct = 6'b100000;
      cyc(1, 0, E_FETCH_R, "add_fetch");
      cyc(0, 1, E_DECODE,  "add_decode");
      cyc(0, 6, E_EXEC,    "add_exec");
      cyc(1, 7, E_ALUWB,   "add_aluwb");
   endtask

   task automatic test_addi_beq();
      op = 6'b001000;
      cyc(1, 0,  E_FETCH_R, "addi_fetch");
      cyc(1, 1,  E_DECODE,  "addi_decode");
      cyc(1, 10, E_MEMADR,  "addi_ex");
      cyc(1, 11, E_ADDIWB,  "addi_wb");
      op = 6'b000100;
      cyc(1, 0, E_FETCH_R, "beq_fetch");
      cyc(1, 1, E_DECODE,  "beq_decode");
      cyc(1, 8, E_BRANCH,  "beq_branch");
   endtask

   task automatic test_sw_fetch_wait();
      op = 6'b101011;
      cyc(0, 0, E_FETCH_W, "sw_fetchwait");
      cyc(1, 0, E_FETCH_R, "sw_fetch");
      cyc(0, 1, E_DECODE,  "sw_decode");
      cyc(0, 2, E_MEMADR,  "sw_memadr");
      cyc(0, 5, E_MEMWR,   "sw_memwr0");
      cyc(1, 5, E_MEMWR,   "sw_memwr1");
   endtask

   task automatic test_jumps();
      op = 6'b000010;
      cyc(1, 0, E_FETCH_R, "j_fetch");
      cyc(1, 1, E_DECODE,  "j_decode");
      cyc(1, 9, E_JUMP,    "j_jump");
      op = 6'b000011;
      cyc(1, 0,  E_FETCH_R, "jal_fetch");
      cyc(1, 1,  E_DECODE,  "jal_decode");
      cyc(1, 12, E_JAL,     "jal_jal");
      op = 6'b000000; funct = 6'b001000;
      cyc(1, 0,  E_FETCH_R, "jr_fetch");
      cyc(1, 1,  E_DECODE,  "jr_decode");
      cyc(1, 13, E_JR,      "jr_jr");
   endtask

   task automatic test_illegal();
      op = 6'b111111; funct = 6'b0;
      cyc(1, 0, E_FETCH_R, "ill_fetch");
      cyc(1, 1, E_ILL,     "ill_decode");
      cyc(0, 0, E_FETCH_W, "ill_refetch");
   endtask

   task automatic test_reset_mid();
      op = 6'b101011;
      cyc(1, 0, E_FETCH_R, "rmid_fetch");
      cyc(1, 1, E_DECODE,  "rmid_decode");
      cyc(1, 2, E_MEMADR,  "rmid_memadr");
      mem_ready = 1'b0;
      #2;
      checks++;
      if (state !== 4'd5 || mem_write !== 1'b1) begin
         errors++;
         $display("FAIL rmid_pre: got state %0d mem_write %b want 5 1", state, mem_write);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (state !== 4'd0) begin errors++; $display("FAIL rmid_state: got %0d want 0", state); end
      checks++;
      if (obs !== E_ZERO) begin errors++; $display("FAIL rmid_ctrl: got %05h want %05h", obs, E_ZERO); end
      checks++;
      if (instr_count !== 32'd0) begin errors++; $display("FAIL rmid_count: got %0d want 0", instr_count); end
      exp_count = 32'd0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_back_to_back();
      cyc(0, 0, E_FETCH_W, "b2b_hold");
      op = 6'b000010;
      cyc(1, 0, E_FETCH_R, "b2b_j_fetch");
      cyc(1, 1, E_DECODE,  "b2b_j_decode");
      cyc(1, 9, E_JUMP,    "b2b_j_jump");
      op = 6'b100011;
      cyc(1, 0, E_FETCH_R, "b2b_lw_fetch");
      cyc(1, 1, E_DECODE,  "b2b_lw_decode");
      cyc(1, 2, E_MEMADR,  "b2b_lw_memadr");
      cyc(1, 3, E_MEMRD,   "b2b_lw_memrd");
      cyc(1, 4, E_MEMWB,   "b2b_lw_memwb");
      cyc(0, 0, E_FETCH_W, "b2b_end");
   endtask

   initial begin
      test_reset();
      test_lw();
      test_lw_wait();
      test_rtype();
      test_addi_beq();
      test_sw_fetch_wait();
      test_jumps();
      test_illegal();
      test_reset_mid();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
